// File: rtl/pattern_serializer_tx_pkg.sv
// Shared constants for the "101" serial pattern family: FSM encoding, preamble and sizing helper.
package pattern_serializer_tx_pkg;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_PRE    = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_GAP    = 3'd3;
    localparam tx_state_t ST_PARITY = 3'd4;

    localparam int unsigned PREAMBLE_LEN = 3;
    localparam logic [PREAMBLE_LEN-1:0] PREAMBLE = 3'b101;

    // Counter must hold the longest phase length without wrapping.
    function automatic int unsigned cnt_width(input int unsigned data_w, input int unsigned gap);
        int unsigned m;
        m = data_w;
        if (gap > m) m = gap;
        if (PREAMBLE_LEN > m) m = PREAMBLE_LEN;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// Parallel-load, shift-left register presenting its MSB; reusable by serializers.
module pattern_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         msb_o
);

    logic [W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
            data_d = data_q << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign msb_o = data_q[W-1];

endmodule

// File: rtl/pattern_serializer_tx.sv
// Bit-serial frame transmitter: preamble 101, DATA_W bits MSB-first, then an idle gap.
// Define PATTERN_TX_PARITY_EN to append an even-parity bit after the data bits.
module pattern_serializer_tx
    import pattern_serializer_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx_bit,
    output logic              tx_en,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CNT_W = cnt_width(DATA_W, GAP_CYCLES);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam tx_state_t        POST_ST   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             frame_done_q, frame_done_d;
    logic             accept;
    logic             sr_msb;
    logic [1:0]       pre_idx;

    // in_ready is a flop reset low, so a word offered as reset releases is not taken.
    assign accept = in_valid && in_ready_q;

`ifdef PATTERN_TX_PARITY_EN
    logic parity_q, parity_d;

    assign parity_d = accept ? ^in_data : parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    pattern_shift_reg #(
        .W(DATA_W)
    ) u_shift_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .shift_i(state_q == ST_DATA),
        .data_i (in_data),
        .msb_o  (sr_msb)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) state_d = ST_PRE;
            end
            ST_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d = '0;
`ifdef PATTERN_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d      = POST_ST;
                    frame_done_d = 1'b1;
`endif
                end
            end
`ifdef PATTERN_TX_PARITY_EN
            ST_PARITY: begin
                state_d      = POST_ST;
                cnt_d        = '0;
                frame_done_d = 1'b1;
            end
`endif
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pre_idx = 2'(PREAMBLE_LEN - 1) - cnt_q[1:0];

    always_comb begin
        tx_en  = 1'b0;
        tx_bit = 1'b0;
        case (state_q)
            ST_PRE: begin
                tx_en  = 1'b1;
                tx_bit = PREAMBLE[pre_idx];
            end
            ST_DATA: begin
                tx_en  = 1'b1;
                tx_bit = sr_msb;
            end
`ifdef PATTERN_TX_PARITY_EN
            ST_PARITY: begin
                tx_en  = 1'b1;
                tx_bit = parity_q;
            end
`endif
            default: begin
                tx_en  = 1'b0;
                tx_bit = 1'b0;
            end
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign in_ready   = in_ready_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pattern_serializer_tx.sv
// Scoreboard bench for pattern_serializer_tx: default 8/2 instance plus a 1-bit, no-gap instance.
module tb_pattern_serializer_tx;

    localparam int unsigned GAP = 2;
`ifdef PATTERN_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif

    logic       clk, rst;
    logic       in_valid, in_ready, tx_bit, tx_en, busy, frame_done;
    logic [7:0] in_data;
    logic       s_valid, s_ready, s_tx_bit, s_tx_en, s_busy, s_done;
    logic [0:0] s_data;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   gap_run  = 0;
    logic done_exp = 1'b0;
    logic sb[$];

    pattern_serializer_tx #(.DATA_W(8), .GAP_CYCLES(GAP)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tx_bit(tx_bit), .tx_en(tx_en), .busy(busy), .frame_done(frame_done)
    );

    pattern_serializer_tx #(.DATA_W(1), .GAP_CYCLES(0)) u_dut_small (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data),
        .tx_bit(s_tx_bit), .tx_en(s_tx_en), .busy(s_busy), .frame_done(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] w);
        sb.push_back(1'b1);
        sb.push_back(1'b0);
        sb.push_back(1'b1);
        for (int i = 7; i >= 0; i--) sb.push_back(w[i]);
        if (PAR != 0) sb.push_back(^w);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] w, output int acc_cyc);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = cyc;
        if (n >= 200) begin
            check("send_timeout", 32'(n), 32'd0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            push_frame(w);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            gap_run = 0;
        end else begin
            check("frame_done", 32'(frame_done), 32'(done_exp));
            done_exp = 1'b0;
            if (busy) check("ready_busy", 32'(in_ready), 32'd0);
            if (tx_en) begin
                check("busy_tx", 32'(busy), 32'd1);
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    check("tx_bit", 32'(tx_bit), 32'(sb.pop_front()));
                    if (sb.size() == 0) done_exp = 1'b1;
                end
            end else if (busy) begin
                gap_run++;
            end else if (gap_run != 0) begin
                check("gap_len", 32'(gap_run), 32'(GAP));
                gap_run = 0;
            end
        end
    end

    initial begin
        int c1, c2, dummy;
        logic sbits[5];
        rst = 1'b1; in_valid = 1'b0; in_data = '0; s_valid = 1'b0; s_data = '0;
        #12;
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_bit", 32'(tx_bit), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        send(8'hA5, dummy);
        wait_idle();

        send(8'h01, c1);
        send(8'h02, c2);
        check("accept_spacing", 32'(c2 - c1), 32'(3 + 8 + PAR + GAP + 1));
        wait_idle();

        send(8'h3C, dummy);
        repeat (16) begin
            @(negedge clk);
            in_data = 8'($urandom);
        end
        wait_idle();

        // Abort during the 5th data bit (8th frame bit).
        send(8'hC3, dummy);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_tx_en", 32'(tx_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tx_bit", 32'(tx_bit), 32'd0);
        check("abort_done", 32'(frame_done), 32'd0);
        sb.delete();
        done_exp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hFF;
        check("release_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("release_no_accept", 32'(busy), 32'd0);
        check("release_ready_up", 32'(in_ready), 32'd1);
        @(negedge clk);
        send(8'hFF, dummy);
        wait_idle();

        send(8'h07, dummy);
        wait_idle();

        // One-bit payload, no gap.
        sbits[0] = 1'b1; sbits[1] = 1'b0; sbits[2] = 1'b1; sbits[3] = 1'b1; sbits[4] = 1'b1;
        s_valid = 1'b1;
        s_data  = 1'b1;
        c1 = 0;
        while (!s_ready && c1 < 50) begin
            @(negedge clk);
            c1++;
        end
        check("small_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < 4 + int'(PAR); i++) begin
            check("small_tx_en", 32'(s_tx_en), 32'd1);
            check("small_tx_bit", 32'(s_tx_bit), 32'(sbits[i]));
            check("small_done_early", 32'(s_done), 32'd0);
            @(negedge clk);
        end
        check("small_tx_en_end", 32'(s_tx_en), 32'd0);
        check("small_ready_end", 32'(s_ready), 32'd1);
        check("small_done", 32'(s_done), 32'd1);
        check("small_busy_end", 32'(s_busy), 32'd0);
        @(negedge clk);
        check("small_done_pulse", 32'(s_done), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
